// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, H/V counters and registered sync/active/coordinate
// outputs. Optional VGA_FRAME_CNT_EN adds an 8-bit frame counter output (Frame_Cnt).
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SW     = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SW     = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       Pix_Tick,
  output logic       H_SYNC,
  output logic       V_SYNC,
  output logic       Active_Flag,
  output logic [9:0] Pixel_X,
  output logic [9:0] Pixel_Y,
  output logic       Frame_Start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] Frame_Cnt
`endif
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SW + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SW + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax    = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast     = 10'(HTotal - 1);
  localparam logic [9:0]      VLast     = 10'(VTotal - 1);
  localparam logic [9:0]      HAct      = 10'(H_ACTIVE);
  localparam logic [9:0]      VAct      = 10'(V_ACTIVE);
  localparam logic [9:0]      HSyncBeg  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]      HSyncEnd  = 10'(H_ACTIVE + H_FP + H_SW - 1);
  localparam logic [9:0]      VSyncBeg  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]      VSyncEnd  = 10'(V_ACTIVE + V_FP + V_SW - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            act_q, act_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            fs_q, fs_d;
  logic            advance;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]      fcnt_q, fcnt_d;
`endif

  always_comb begin
    // Advance decodes the divider directly so that CLK_DIV=1 steps on the very first edge
    // after release; otherwise it coincides with the registered Pix_Tick.
    advance = (div_q == DivMax);
    div_d   = advance ? '0 : div_q + 1'b1;
    tick_d  = (div_d == DivMax);

    h_d   = h_q;
    v_d   = v_q;
    x_d   = x_q;
    y_d   = y_q;
    act_d = act_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = 1'b0;

    if (advance) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // All outputs are decoded from the next counter values so they change together.
      x_d   = h_d;
      y_d   = v_d;
      act_d = (h_d < HAct) && (v_d < VAct);
      hs_d  = ((h_d >= HSyncBeg) && (h_d <= HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = ((v_d >= VSyncBeg) && (v_d <= VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
      fs_d  = (h_d == '0) && (v_d == '0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_comb begin
    fcnt_d = fs_d ? fcnt_q + 8'd1 : fcnt_q;
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      h_q    <= HLast;
      v_q    <= VLast;
      x_q    <= '0;
      y_q    <= '0;
      act_q  <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      fs_q   <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      fcnt_q <= '0;
`endif
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      v_q    <= v_d;
      x_q    <= x_d;
      y_q    <= y_d;
      act_q  <= act_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
`ifdef VGA_FRAME_CNT_EN
      fcnt_q <= fcnt_d;
`endif
    end
  end

  assign Pix_Tick    = tick_q;
  assign H_SYNC      = hs_q;
  assign V_SYNC      = vs_q;
  assign Active_Flag = act_q;
  assign Pixel_X     = x_q;
  assign Pixel_Y     = y_q;
  assign Frame_Start = fs_q;
`ifdef VGA_FRAME_CNT_EN
  assign Frame_Cnt   = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: two reduced-timing instances (CLK_DIV=4 active-low sync,
// CLK_DIV=1 active-high sync) checked every cycle against an arithmetic pixel-position model.
module tb_vga_sync_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick4, hs4, vs4, act4, fs4;
  logic [9:0] x4, y4;
  logic       tick1, hs1, vs1, act1, fs1;
  logic [9:0] x1, y1;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fc4, fc1;
`endif

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut4 (
    .CLK(clk), .RST(rst_n), .Pix_Tick(tick4), .H_SYNC(hs4), .V_SYNC(vs4),
    .Active_Flag(act4), .Pixel_X(x4), .Pixel_Y(y4), .Frame_Start(fs4)
`ifdef VGA_FRAME_CNT_EN
    , .Frame_Cnt(fc4)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut1 (
    .CLK(clk), .RST(rst_n), .Pix_Tick(tick1), .H_SYNC(hs1), .V_SYNC(vs1),
    .Active_Flag(act1), .Pixel_X(x1), .Pixel_Y(y1), .Frame_Start(fs1)
`ifdef VGA_FRAME_CNT_EN
    , .Frame_Cnt(fc1)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int k = 0;
  int hs_run = 0;
  int prev_fs = -1;
  logic [24:0] q4[$];
  logic [24:0] q1[$];

  // Expected {tick, hs, vs, active, fs, x, y} after kk clock edges since reset release.
  function automatic logic [24:0] model(int kk, int cd, bit pol);
    int n, p, x, y;
    logic tk, hs, vs, ac, fs;
    tk = (kk > 0) && ((kk % cd) == cd - 1);
    n  = kk / cd;
    if (n == 0) return {tk, ~pol, ~pol, 1'b0, 1'b0, 10'd0, 10'd0};
    p  = (n - 1) % (HT * VT);
    x  = p % HT;
    y  = p / HT;
    ac = (x < HA) && (y < VA);
    hs = (x >= HA + HF && x < HA + HF + HS) ? pol : ~pol;
    vs = (y >= VA + VF && y < VA + VF + VS) ? pol : ~pol;
    fs = ((kk % cd) == 0) && (p == 0);
    return {tk, hs, vs, ac, fs, 10'(x), 10'(y)};
  endfunction

  function automatic int fcnt_model(int kk, int cd);
    int n;
    n = kk / cd;
    return (n == 0) ? 0 : ((n - 1) / (HT * VT) + 1) % 256;
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
  endtask

  task automatic sample();
    logic [24:0] e;
    e = q4.pop_front();
    check_eq("dut4_outputs", {7'd0, tick4, hs4, vs4, act4, fs4, x4, y4}, {7'd0, e});
    e = q1.pop_front();
    check_eq("dut1_outputs", {7'd0, tick1, hs1, vs1, act1, fs1, x1, y1}, {7'd0, e});
`ifdef VGA_FRAME_CNT_EN
    check_eq("frame_cnt4", {24'd0, fc4}, fcnt_model(k, 4));
    check_eq("frame_cnt1", {24'd0, fc1}, fcnt_model(k, 1));
`endif
    if (rst_n) begin
      if (hs4 == 1'b0) hs_run++;
      else if (hs_run > 0) begin
        check_eq("hsync_len4", hs_run, HS * 4);
        hs_run = 0;
      end
      if (fs4) begin
        if (prev_fs < 0) check_eq("fs_latency4", k, 4);
        else check_eq("fs_period4", k - prev_fs, HT * VT * 4);
        prev_fs = k;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) k++;
    q4.push_back(model(k, 4, 1'b0));
    q1.push_back(model(k, 1, 1'b1));
    @(negedge clk);
    sample();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (20) step();
    rst_n = 1'b1;
    repeat (3 * HT * VT * 4 + 10) step();

    // Walk to (11,3) on the divided instance, inside its horizontal sync pulse.
    for (int i = 0; i < 4 * HT * VT; i++) begin
      if (x4 == 10'd11 && y4 == 10'd3) break;
      step();
    end
    check_eq("mid_frame_pos", {12'd0, y4, x4}, {12'd0, 10'd3, 10'd11});
    check_eq("mid_frame_hs_active", {31'd0, hs4}, 32'd0);

    #2 rst_n = 1'b0;
    #1;
    check_eq("async_hs4", {31'd0, hs4}, 32'd1);
    check_eq("async_hs1", {31'd0, hs1}, 32'd0);
    check_eq("async_xy4", {12'd0, y4, x4}, 32'd0);
    check_eq("async_act4", {31'd0, act4}, 32'd0);
    k = 0;
    hs_run = 0;
    prev_fs = -1;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (HT * VT * 4 + 50) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- VGA timing generator; sits directly upstream of the name-display pixel stage.
- Divides the system clock to a pixel tick and runs horizontal/vertical counters.
- Produces H_SYNC, V_SYNC, Active_Flag, pixel coordinates and frame strobe; downstream consumes these to drive R/G/B.
- Default timing: 640x480@60 from 100 MHz CLK (25 MHz pixel rate).

Parameters:
- CLK_DIV, 4, CLK cycles per pixel; must be >= 1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SW, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SW, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_POL, 0, sync active level (0 = active-low pulses).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-low.
- Pix_Tick  output  1  one-CLK pulse, last CLK cycle of each pixel period.
- H_SYNC  output  1  horizontal sync.
- V_SYNC  output  1  vertical sync.
- Active_Flag  output  1  high while the current pixel is in the visible area.
- Pixel_X  output  10  horizontal count, 0..H_TOTAL-1.
- Pixel_Y  output  10  vertical count, 0..V_TOTAL-1.
- Frame_Start  output  1  one-CLK pulse on the first CLK cycle of pixel (0,0).

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SW+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SW+V_BP (525).
- Reset (RST=0, asynchronous):
  - Divider = 0.
  - Internal H counter = H_TOTAL-1; internal V counter = V_TOTAL-1.
  - Outputs: Pixel_X=0, Pixel_Y=0, Active_Flag=0, Frame_Start=0, Pix_Tick=0.
  - H_SYNC and V_SYNC at their inactive level (~SYNC_POL).
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - Pix_Tick is registered and high while divider == CLK_DIV-1.
  - CLK_DIV=1 gives Pix_Tick constantly high after reset release.
- Counter advance, on each CLK edge where Pix_Tick is high:
  - H increments; at H_TOTAL-1 it wraps to 0 and V increments.
  - V wraps from V_TOTAL-1 to 0 when H wraps.
- Output registration:
  - All outputs are registered from the next counter values on the same edge. No skew between coordinates, syncs and Active_Flag.
  - Each output holds for exactly CLK_DIV cycles per pixel.
- Decode:
  - Active_Flag = (X < H_ACTIVE) && (Y < V_ACTIVE).
  - H_SYNC active for X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SW-1] (656..751).
  - V_SYNC active for Y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SW-1] (490..491). V_SYNC is line-based and changes only at the X=0 boundary.
- Start-up: first advance after reset release lands on (0,0) with Frame_Start=1. First visible pixel begins CLK_DIV cycles after release.
- Frame_Start: high for one CLK only (first cycle of (0,0)), every frame.
- Reset mid-frame: immediate return to reset values. No partial sync pulse is extended; the sync output drops to inactive asynchronously.
- Pixel_X and Pixel_Y continue counting through blanking; consumers gate on Active_Flag.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output port Frame_Cnt [7:0], reset to 0.
  - Increments on each Frame_Start pulse, wraps 255->0. Used by display stages for animation or blink.
- Undefined: port and counter are absent; all other behaviour identical.

Test Plan:
- Reset: hold RST=0 for 20 CLK -> H_SYNC=1, V_SYNC=1, Active_Flag=0, Pixel_X=0, Pixel_Y=0, Frame_Start=0. Release -> Frame_Start pulse exactly 4 CLK later, Active_Flag=1 at (0,0).
- Line timing, defaults: H_SYNC low for 384 CLK, period 3200 CLK; Active_Flag high 2560 CLK per visible line; H_SYNC falls when Pixel_X becomes 656.
- Frame timing: V_SYNC low for 6400 CLK starting when Pixel_Y=490; Frame_Start period 1,680,000 CLK; Active_Flag never high for Pixel_Y >= 480.
- Mid-frame reset: assert RST at Pixel_Y=200, Pixel_X=700 (H_SYNC active) -> H_SYNC=1 within the same CLK cycle, all outputs at reset values. On release, restart at (0,0).
- CLK_DIV=1 build: Pix_Tick=1 every cycle after release; line period 800 CLK, H_SYNC low 96 CLK.
- VGA_FRAME_CNT_EN build: run 257 frames -> Frame_Cnt steps 0->1 at the 1st Frame_Start after release, reads 255 after 255 frames, and 0 after 256.
